mctrl_fsm: RTL and testbench
============================

# mctrl_fsm

Multi-cycle MIPS main control unit: a Moore state machine that, given the opcode of the fetched instruction, sequences the FETCH, DECODE, EXECUTE, MEM and WRITEBACK steps. It drives the datapath control word each cycle and stalls on a memory ready handshake. It succeeds the single-cycle opcode decoder and sits between the instruction register and the shared multi-cycle datapath (PC, IR, MDR, register file, ALU, ALU control).

## Interface
- OP_W, 6, opcode width
- ALUOP_W, 3, width of ALU_op_o to the ALU-control block
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- instr_op_i  in  OP_W  opcode from IR[31:26]; sampled in DECODE only
- mem_ready_i  in  1  memory access completes this cycle
- PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, MemtoReg_o, RegWrite_o, RegDst_o, ALUSrcA_o  out  1 each  datapath controls
- ALUSrcB_o  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- PCSource_o  out  2  00=ALU result, 01=ALUOut, 10=jump target
- ALU_op_o  out  ALUOP_W  000=R-type (decode funct), 001=subtract (beq), 010=add
- instr_done_o  out  1  one-cycle pulse in the final cycle of each instruction
- illegal_o  out  1  sticky: unsupported opcode decoded
- state_o  out  4  current state encoding (debug)

## Operation
- States: RST, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, WB_R, EXEC_I, WB_I, BRANCH, JUMP, TRAP.
- RST: all outputs 0; next state FETCH unconditionally.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_op=010, PCSource=00. IRWrite and PCWrite assert only when mem_ready_i=1. The state stays in FETCH while mem_ready_i=0; it moves to DECODE when mem_ready_i=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALU_op=010 (branch target precompute). Dispatch on instr_op_i:
  - 000000 → EXEC_R
  - 001000 (addi) → EXEC_I
  - 100011 (lw) or 101011 (sw) → MEM_ADDR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - any other opcode → TRAP
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALU_op=000 → WB_R.
- WB_R: RegWrite=1, RegDst=1, MemtoReg=0, done → FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALU_op=010 → WB_I.
- WB_I: RegWrite=1, RegDst=0, MemtoReg=0, done → FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALU_op=010. Next state MEM_RD for lw, MEM_WR for sw. The opcode is latched in DECODE; the live input is not re-read here.
- MEM_RD: MemRead=1, IorD=1. Holds until mem_ready_i=1, then → MEM_WB.
- MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1, done → FETCH.
- MEM_WR: MemWrite=1, IorD=1. Holds until mem_ready_i=1; done pulses in the ready cycle, then → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_op=001, PCWriteCond=1, PCSource=01, done → FETCH.
- JUMP: PCWrite=1, PCSource=10, done → FETCH.
- TRAP: all controls 0, illegal_o=1. TRAP is absorbing; only rst_i exits it.
- Any control not listed for a state is 0.

## Timing
- Instruction cost with mem_ready_i tied high: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3 cycles. Each low cycle of mem_ready_i adds one cycle in FETCH, MEM_RD or MEM_WR.
- Outputs are registered-state decodes. Only IRWrite/PCWrite in FETCH and instr_done_o in MEM_WR are qualified combinationally by mem_ready_i.
- rst_i assertion at any point, including mid-stall, forces state RST asynchronously. All outputs, including illegal_o, read 0 in the same cycle. The first FETCH occurs in the second rising edge after rst_i deasserts.
- instr_op_i changes outside DECODE have no effect.

## Configuration
- MCTRL_JUMP_EN defined: opcode 000010 is dispatched to JUMP and PCSource=10 is reachable.
- MCTRL_JUMP_EN undefined: the JUMP state is not built, 000010 goes to TRAP, and PCSource never equals 10.

## Structure
- mctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J)
  - the state enum (4-bit)
  - ALU_op codes
  - a packed control-word struct
- One sub-module, mctrl_out_lut: a combinational state → control-word table. The FSM top owns the state register, the latched opcode, mem_ready_i qualification and the sticky illegal flag.

## Test plan
- Reset, then lw (100011) with mem_ready_i high → states RST, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB. RegWrite=1, MemtoReg=1 in the 6th cycle; one instr_done_o pulse.
- R-type, with mem_ready_i low for 3 FETCH cycles → IRWrite and PCWrite stay 0 for those 3 cycles and assert once. The instruction completes in 7 cycles.
- beq, then sw with 2 wait cycles in MEM_WR → PCWriteCond=1, ALU_op=001 in BRANCH. MemWrite held 3 cycles; done pulses only in the ready cycle.
- Opcode 111111 → TRAP and illegal_o=1 held for 20 cycles regardless of inputs. rst_i pulse clears it to 0.
- rst_i asserted mid-stall in MEM_RD → state_o=RST and all outputs 0 immediately, before the next clock edge.
- j with MCTRL_JUMP_EN defined → PCWrite=1, PCSource=10 in cycle 3. Without the macro, the same opcode → illegal_o=1.

Source files
------------

// File: rtl/mctrl_pkg.sv
// mctrl_pkg: opcodes, state enum, ALU-op codes and control word for the multi-cycle MIPS control FSM.
// MCTRL_JUMP_EN enables dispatch of the j opcode to the JUMP state.
package mctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_R   = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;

    typedef enum logic [3:0] {
        RST      = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        MEM_WB   = 4'd5,
        MEM_WR   = 4'd6,
        EXEC_R   = 4'd7,
        WB_R     = 4'd8,
        EXEC_I   = 4'd9,
        WB_I     = 4'd10,
        BRANCH   = 4'd11,
        JUMP     = 4'd12,
        TRAP     = 4'd13
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       done;
    } ctrl_t;

    function automatic state_e dispatch(input logic [5:0] op);
        state_e s;
        s = TRAP;
        if (op == OP_RTYPE) s = EXEC_R;
        if (op == OP_ADDI) s = EXEC_I;
        if (op == OP_LW || op == OP_SW) s = MEM_ADDR;
        if (op == OP_BEQ) s = BRANCH;
`ifdef MCTRL_JUMP_EN
        if (op == OP_J) s = JUMP;
`endif
        return s;
    endfunction

endpackage

// File: rtl/mctrl_out_lut.sv
// mctrl_out_lut: combinational state -> control-word table (unqualified by mem_ready).
// The JUMP entry exists only when MCTRL_JUMP_EN is defined.
module mctrl_out_lut
    import mctrl_pkg::*;
(
    input  state_e state_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.alu_src_b = 2'b01;
                ctrl_o.alu_op    = ALU_ADD;
            end
            DECODE: begin
                ctrl_o.alu_src_b = 2'b11;
                ctrl_o.alu_op    = ALU_ADD;
            end
            MEM_ADDR, EXEC_I: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = 2'b10;
                ctrl_o.alu_op    = ALU_ADD;
            end
            MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.done       = 1'b1;
            end
            MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
                ctrl_o.done      = 1'b1;
            end
            EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALU_R;
            end
            WB_R: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.done      = 1'b1;
            end
            WB_I: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.done      = 1'b1;
            end
            BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = 2'b01;
                ctrl_o.done          = 1'b1;
            end
`ifdef MCTRL_JUMP_EN
            JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = 2'b10;
                ctrl_o.done      = 1'b1;
            end
`endif
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mctrl_fsm.sv
// mctrl_fsm: multi-cycle MIPS main control FSM with memory-ready stalls and sticky illegal-opcode trap.
// MCTRL_JUMP_EN enables the j instruction; otherwise opcode 000010 traps.
module mctrl_fsm
    import mctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    instr_op_i,
    input  logic               mem_ready_i,
    output logic               PCWrite_o,
    output logic               PCWriteCond_o,
    output logic               IorD_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               IRWrite_o,
    output logic               MemtoReg_o,
    output logic               RegWrite_o,
    output logic               RegDst_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic [1:0]         PCSource_o,
    output logic [ALUOP_W-1:0] ALU_op_o,
    output logic               instr_done_o,
    output logic               illegal_o,
    output logic [3:0]         state_o
);

    state_e          state_q, state_d;
    logic [OP_W-1:0] op_q;
    logic            illegal_q;
    ctrl_t           cw;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RST;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= (state_q == DECODE) ? instr_op_i : op_q;
            illegal_q <= illegal_q | (state_d == TRAP);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RST:      state_d = FETCH;
            FETCH:    state_d = mem_ready_i ? DECODE : FETCH;
            DECODE:   state_d = dispatch(instr_op_i);
            MEM_ADDR: state_d = (op_q == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   state_d = mem_ready_i ? MEM_WB : MEM_RD;
            MEM_WR:   state_d = mem_ready_i ? FETCH : MEM_WR;
            EXEC_R:   state_d = WB_R;
            EXEC_I:   state_d = WB_I;
            MEM_WB, WB_R, WB_I, BRANCH, JUMP: state_d = FETCH;
            TRAP:     state_d = TRAP;
            default:  state_d = RST;
        endcase
    end

    mctrl_out_lut u_lut (
        .state_i (state_q),
        .ctrl_o  (cw)
    );

    // Only the FETCH write strobes and the MEM_WR done pulse wait on the memory handshake.
    assign PCWrite_o     = cw.pc_write & (mem_ready_i | (state_q != FETCH));
    assign IRWrite_o     = cw.ir_write & mem_ready_i;
    assign instr_done_o  = cw.done & (mem_ready_i | (state_q != MEM_WR));
    assign PCWriteCond_o = cw.pc_write_cond;
    assign IorD_o        = cw.iord;
    assign MemRead_o     = cw.mem_read;
    assign MemWrite_o    = cw.mem_write;
    assign MemtoReg_o    = cw.mem_to_reg;
    assign RegWrite_o    = cw.reg_write;
    assign RegDst_o      = cw.reg_dst;
    assign ALUSrcA_o     = cw.alu_src_a;
    assign ALUSrcB_o     = cw.alu_src_b;
    assign PCSource_o    = cw.pc_source;
    assign ALU_op_o      = ALUOP_W'(cw.alu_op);
    assign illegal_o     = illegal_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_mctrl_fsm.sv
// tb_mctrl_fsm: directed per-cycle vectors feed an expectation queue; a negedge monitor pops and compares.
module tb_mctrl_fsm;
    import mctrl_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       ill, done, pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, asa;
        logic [1:0] asb, pcs;
        logic [2:0] aop;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = '0;
    logic       rdy = 1'b0;
    logic       pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, asa, done, ill;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    logic [3:0] st;

    obs_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    mctrl_fsm dut (
        .clk_i(clk), .rst_i(rst), .instr_op_i(op), .mem_ready_i(rdy),
        .PCWrite_o(pcw), .PCWriteCond_o(pcwc), .IorD_o(iord), .MemRead_o(mr),
        .MemWrite_o(mw), .IRWrite_o(irw), .MemtoReg_o(m2r), .RegWrite_o(rw),
        .RegDst_o(rd), .ALUSrcA_o(asa), .ALUSrcB_o(asb), .PCSource_o(pcs),
        .ALU_op_o(aop), .instr_done_o(done), .illegal_o(ill), .state_o(st)
    );

    // Expected control word for a state, written out from the state descriptions.
    function automatic obs_t exp_for(input state_e s, input logic r);
        obs_t o;
        o = '0;
        o.st = s;
        case (s)
            FETCH:    begin o.mr = 1; o.asb = 2'b01; o.aop = 3'b010; o.irw = r; o.pcw = r; end
            DECODE:   begin o.asb = 2'b11; o.aop = 3'b010; end
            MEM_ADDR: begin o.asa = 1; o.asb = 2'b10; o.aop = 3'b010; end
            MEM_RD:   begin o.mr = 1; o.iord = 1; end
            MEM_WB:   begin o.rw = 1; o.m2r = 1; o.done = 1; end
            MEM_WR:   begin o.mw = 1; o.iord = 1; o.done = r; end
            EXEC_R:   begin o.asa = 1; o.asb = 2'b00; o.aop = 3'b000; end
            WB_R:     begin o.rw = 1; o.rd = 1; o.done = 1; end
            EXEC_I:   begin o.asa = 1; o.asb = 2'b10; o.aop = 3'b010; end
            WB_I:     begin o.rw = 1; o.done = 1; end
            BRANCH:   begin o.asa = 1; o.aop = 3'b001; o.pcwc = 1; o.pcs = 2'b01; o.done = 1; end
            JUMP:     begin o.pcw = 1; o.pcs = 2'b10; o.done = 1; end
            TRAP:     o.ill = 1;
            default:  o.st = s;
        endcase
        return o;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t got, e;
            string nm;
            got = {st, ill, done, pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, asa, asb, pcs, aop};
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got %h required %h", nm, got, e);
            end
        end
    end

    task automatic expect_now(input state_e s, input logic r, input string nm);
        exp_q.push_back(exp_for(s, r));
        name_q.push_back(nm);
    endtask

    task automatic step(input logic [5:0] o, input logic r, input state_e s, input string nm);
        op = o;
        rdy = r;
        expect_now(s, r, nm);
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse(input string nm);
        rst = 1'b1;
        expect_now(RST, rdy, nm);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(6'h00, 1'b1, RST, {nm, "_rel"});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        step(6'h00, 1'b0, RST, "rst_hold");
        rst = 1'b0;
        step(6'h00, 1'b1, RST, "rst_rel");
        // lw, no stalls; live opcode changes after DECODE must be ignored
        step(OP_LW, 1, FETCH, "lw_fetch");
        step(OP_LW, 1, DECODE, "lw_decode");
        step(6'h00, 1, MEM_ADDR, "lw_addr");
        step(OP_SW, 1, MEM_RD, "lw_rd");
        step(6'h00, 1, MEM_WB, "lw_wb");
        // R-type with 3 fetch stall cycles
        for (int i = 0; i < 3; i++) step(6'h3f, 0, FETCH, "r_fetch_stall");
        step(6'h3f, 1, FETCH, "r_fetch");
        step(OP_RTYPE, 1, DECODE, "r_decode");
        step(6'h3f, 1, EXEC_R, "r_exec");
        step(6'h3f, 1, WB_R, "r_wb");
        // beq
        step(OP_BEQ, 1, FETCH, "beq_fetch");
        step(OP_BEQ, 1, DECODE, "beq_decode");
        step(OP_BEQ, 1, BRANCH, "beq_branch");
        // sw with two wait cycles
        step(OP_SW, 1, FETCH, "sw_fetch");
        step(OP_SW, 1, DECODE, "sw_decode");
        step(OP_LW, 1, MEM_ADDR, "sw_addr");
        step(OP_LW, 0, MEM_WR, "sw_wait0");
        step(OP_LW, 0, MEM_WR, "sw_wait1");
        step(OP_LW, 1, MEM_WR, "sw_ready");
        // addi
        step(OP_ADDI, 1, FETCH, "addi_fetch");
        step(OP_ADDI, 1, DECODE, "addi_decode");
        step(OP_ADDI, 1, EXEC_I, "addi_exec");
        step(OP_ADDI, 1, WB_I, "addi_wb");
        // lw stalled in MEM_RD, then asynchronous reset mid-cycle
        step(OP_LW, 1, FETCH, "lw2_fetch");
        step(OP_LW, 1, DECODE, "lw2_decode");
        step(OP_LW, 0, MEM_ADDR, "lw2_addr");
        step(OP_LW, 0, MEM_RD, "lw2_stall0");
        step(OP_LW, 0, MEM_RD, "lw2_stall1");
        #1;
        rst_pulse("rst_async");
        // j
        step(OP_J, 1, FETCH, "j_fetch");
        step(OP_J, 1, DECODE, "j_decode");
`ifdef MCTRL_JUMP_EN
        step(OP_J, 1, JUMP, "j_jump");
        step(6'h3f, 1, FETCH, "trap_fetch");
`else
        step(OP_J, 1, TRAP, "j_trap");
        rst_pulse("j_trap_clr");
        step(6'h3f, 1, FETCH, "trap_fetch");
`endif
        // illegal opcode: absorbing trap, cleared only by reset
        step(6'h3f, 1, DECODE, "trap_decode");
        for (int i = 0; i < 20; i++)
            step(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), TRAP, "trap_hold");
        rst_pulse("trap_clr");
        step(OP_RTYPE, 1, FETCH, "post_trap_fetch");
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
